aggr_buffer: RTL
================

Name: aggr_buffer

Overview:
- Aggregation buffer that sits directly downstream of the SIMD add/sub core.
- Stores each 128-bit lane-packed partial result at a 10-bit entry address.
- Returns stored entries as operands for the next aggregation round.
- Owns its own initialisation and clear sweep, so it always presents zeroed entries after reset or a clear request.

Parameters:
- DW, 128, entry width in bits (16 lanes x 8 bit)
- AW, 10, address width
- DEPTH, 1024, number of entries; must equal 2**AW

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clr_req  input  1  one-cycle pulse; request a full zero sweep
- ready  output  1  high when reads and writes are accepted
- wr_en  input  1  write strobe from SIMD core (data_W)
- wr_addr  input  AW  write entry address
- wr_data  input  DW  write data (SIMD data_out)
- rd_en  input  1  read strobe (data_R)
- rd_addr  input  AW  read entry address
- rd_data  output  DW  registered read data
- rd_valid  output  1  pulses high one cycle after an accepted read
- wr_count  output  AW+1  number of distinct entries written since the last clear, saturating at DEPTH

Behaviour:
- Interface:
  - One clock, clk. Reset rst is synchronous and active-high.
- FSM states are CLEAR and RUN.
  - rst forces CLEAR with sweep counter = 0. rst takes priority over every other input, including mid-sweep and mid-access.
  - CLEAR: writes zero to entry[sweep], then increments sweep by one each cycle. After entry DEPTH-1 is written, moves to RUN.
  - A full sweep takes exactly DEPTH cycles from the first CLEAR cycle.
  - RUN: when clr_req=1, the next state is CLEAR with sweep = 0. Any rd_en or wr_en in that same cycle is still accepted.
- ready:
  - ready = 1 only in RUN.
  - wr_en and rd_en are ignored while ready = 0: no write, no rd_valid.
- Write:
  - An accepted write updates entry[wr_addr] at the clock edge.
  - A per-entry written flag is set. If the flag was clear, wr_count increments by one.
  - Rewriting the same address does not change wr_count.
  - CLEAR clears all flags and sets wr_count = 0 on its first cycle.
- Read:
  - An accepted read at edge N gives rd_data = entry[rd_addr] and rd_valid = 1 after edge N+1 (latency 1).
  - When no read is accepted, rd_valid = 0 and rd_data holds its last value.
- Simultaneous read and write to the same address: rd_data returns the pre-write contents unless the bypass option is compiled in.
- Reads and writes to different addresses in the same cycle are both serviced.
- Addresses wrap naturally at AW bits; there is no out-of-range case.
- Reset values: ready = 0, rd_valid = 0, rd_data = 0, wr_count = 0.

Optional Feature:
- Macro: AGGR_BYPASS_EN.
- Defined: when wr_en and rd_en are both accepted with wr_addr == rd_addr, rd_data takes wr_data (write-first forwarding).
- Undefined: rd_data takes the old entry contents (read-first), and no forwarding comparator is built.

Decomposition:
- Shared package aggr_pkg holds:
  - AGGR_DW, AGGR_AW, AGGR_DEPTH constants
  - the FSM state type {AGGR_CLEAR, AGGR_RUN}
  - a lane-count constant (16), shared with the SIMD core.
- Sub-module aggr_mem_1r1w: plain DEPTH x DW memory with one synchronous write port, one synchronous read port, and read-first semantics, so it maps to block RAM.
- The FSM, written flags, counter and bypass logic stay in aggr_buffer.

Test Plan:
- Reset -> hold rst for 2 cycles, release -> ready stays 0 for exactly 1024 cycles, then 1; wr_count = 0; a read of address 0x3FF returns 0 with rd_valid after 1 cycle.
- Write then read -> write 0x0102...10 to address 5, next cycle read address 5 -> rd_data = 0x0102...10 one cycle later; wr_count = 1; rewrite address 5 leaves wr_count = 1.
- Same-cycle write/read to address 7 (old value 0xAA.., new 0x55..) -> rd_data = 0xAA.. without AGGR_BYPASS_EN, 0x55.. with it.
- clr_req while writing address 9 = 0x11.. -> the write lands, then ready = 0 for 1024 cycles; afterwards address 9 reads 0 and wr_count = 0; wr_en/rd_en pulses during CLEAR produce no rd_valid and no memory change.
- rst asserted 300 cycles into a sweep -> sweep restarts at 0, and ready rises exactly 1024 cycles after rst is released.
- Fill all 1024 addresses with distinct data -> wr_count = 1024 (saturated); all read back correctly, back-to-back one read per cycle with rd_valid continuously high.

Source files
------------

// File: rtl/aggr_pkg.sv
// Shared constants and types for the aggregation buffer and SIMD core.
// Optional write-first forwarding is enabled with AGGR_BYPASS_EN.
package aggr_pkg;

    localparam int AGGR_DW     = 128;
    localparam int AGGR_AW     = 10;
    localparam int AGGR_DEPTH  = 1 << AGGR_AW;
    localparam int AGGR_LANES  = 16;
    localparam int AGGR_LANE_W = AGGR_DW / AGGR_LANES;

    typedef enum logic {
        AGGR_CLEAR = 1'b0,
        AGGR_RUN   = 1'b1
    } aggr_state_e;

endpackage

// File: rtl/aggr_mem_1r1w.sv
// Plain DEPTH x DW memory, one write and one read port, read-first.
// Only the read output register is reset so the array maps to block RAM.
module aggr_mem_1r1w
    import aggr_pkg::*;
#(
    parameter int DW    = AGGR_DW,
    parameter int AW    = AGGR_AW,
    parameter int DEPTH = AGGR_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/aggr_buffer.sv
// Aggregation buffer behind the SIMD add/sub core, with self-clearing sweep.
// Define AGGR_BYPASS_EN for write-first forwarding on same-address access.
module aggr_buffer
    import aggr_pkg::*;
#(
    parameter int DW    = AGGR_DW,
    parameter int AW    = AGGR_AW,
    parameter int DEPTH = AGGR_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   wr_count
);

    aggr_state_e   r_state;
    aggr_state_e   w_state_nxt;
    logic [AW-1:0] r_sweep;
    logic          w_sweep_last;
    logic          w_ready;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [DEPTH-1:0] r_flags;
    logic [AW:0]   r_wr_count;
    logic          r_rd_valid;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_mem_rdata;

    assign w_sweep_last = (r_sweep == AW'(DEPTH - 1));
    assign w_wr_acc     = w_ready && wr_en;
    assign w_rd_acc     = w_ready && rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= AGGR_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            AGGR_CLEAR: if (w_sweep_last) w_state_nxt = AGGR_RUN;
            AGGR_RUN:   if (clr_req)      w_state_nxt = AGGR_CLEAR;
            default:    w_state_nxt = AGGR_CLEAR;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            AGGR_RUN: w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep <= '0;
        end else if (r_state == AGGR_CLEAR) begin
            r_sweep <= r_sweep + 1'b1;
        end else if (clr_req) begin
            r_sweep <= '0;
        end
    end

    // The sweep owns the write port while clearing; user writes are gated.
    always_comb begin
        w_mem_we    = w_wr_acc;
        w_mem_waddr = wr_addr;
        w_mem_wdata = wr_data;
        if (r_state == AGGR_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_sweep;
            w_mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == AGGR_CLEAR) begin
            r_flags    <= '0;
            r_wr_count <= '0;
        end else if (w_wr_acc) begin
            r_flags[wr_addr] <= 1'b1;
            if (!r_flags[wr_addr] && r_wr_count != (AW+1)'(DEPTH)) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
        end
    end

    aggr_mem_1r1w #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_mem_we),
        .waddr (w_mem_waddr),
        .wdata (w_mem_wdata),
        .re    (w_rd_acc),
        .raddr (rd_addr),
        .rdata (w_mem_rdata)
    );

`ifdef AGGR_BYPASS_EN
    logic          r_fwd;
    logic [DW-1:0] r_fwd_data;

    // Selection is only updated on accepted reads so rd_data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else if (w_rd_acc) begin
            r_fwd      <= w_wr_acc && (wr_addr == rd_addr);
            r_fwd_data <= wr_data;
        end
    end

    assign rd_data = r_fwd ? r_fwd_data : w_mem_rdata;
`else
    assign rd_data = w_mem_rdata;
`endif

    assign ready    = w_ready;
    assign rd_valid = r_rd_valid;
    assign wr_count = r_wr_count;

endmodule
